// File: rtl/iir_deemph_if.sv
// FIFO-side handshake bundle for iir_deemph: input-FIFO pop side and output-FIFO push side.
// The filter uses the slave modport; the FIFO side (or a testbench) uses master.
interface iir_deemph_if #(
  parameter int DATA_SIZE = 32
);
  logic signed [DATA_SIZE-1:0] in;
  logic                        in_empty;
  logic                        in_rd_en;
  logic signed [DATA_SIZE-1:0] out;
  logic                        out_full;
  logic                        out_wr_en;

  modport master (
    output in, in_empty, out_full,
    input  in_rd_en, out, out_wr_en
  );

  modport slave (
    input  in, in_empty, out_full,
    output in_rd_en, out, out_wr_en
  );
endinterface

// File: rtl/iir_deemph.sv
// First-order IIR de-emphasis: y[n] = DQ(x[n]*X0) + DQ(x[n-1]*X1) + DQ(y[n-1]*Y1), Q(BITS), round toward zero.
// Define IIR_SAT_EN to clamp the sum to the DATA_SIZE range instead of wrapping.
module iir_deemph #(
  parameter int                          DATA_SIZE = 32,
  parameter int                          BITS      = 10,
  parameter logic signed [DATA_SIZE-1:0] X_COEFF0  = 178,
  parameter logic signed [DATA_SIZE-1:0] X_COEFF1  = 178,
  parameter logic signed [DATA_SIZE-1:0] Y_COEFF1  = 667
) (
  input logic          clock,
  input logic          reset,
  iir_deemph_if.slave  bus
);

  localparam int PW = 2 * DATA_SIZE;
  localparam int SW = PW + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic signed [DATA_SIZE-1:0] x0;
  logic signed [DATA_SIZE-1:0] x1;
  logic signed [DATA_SIZE-1:0] y1;
  logic signed [DATA_SIZE-1:0] y_reg;
  logic signed [DATA_SIZE-1:0] y_next;
  logic signed [PW-1:0]        p0;
  logic signed [PW-1:0]        p1;
  logic signed [PW-1:0]        p2;
  logic signed [SW-1:0]        sum;
  logic                        pop;
  logic                        push;

  function automatic logic signed [PW-1:0] dq(input logic signed [PW-1:0] v);
    if (v[PW-1])
      return -((-v) >>> BITS);
    else
      return v >>> BITS;
  endfunction

  // Never pop the input FIFO while held in reset.
  assign pop  = (state == IDLE) && !bus.in_empty && !reset;
  assign push = (state == WRITE) && !bus.out_full;

  assign p0  = PW'(x0) * PW'(X_COEFF0);
  assign p1  = PW'(x1) * PW'(X_COEFF1);
  assign p2  = PW'(y1) * PW'(Y_COEFF1);
  assign sum = SW'(dq(p0)) + SW'(dq(p1)) + SW'(dq(p2));

`ifdef IIR_SAT_EN
  always_comb begin
    y_next = sum[DATA_SIZE-1:0];
    if (sum[SW-1:DATA_SIZE-1] != {(SW-DATA_SIZE+1){sum[SW-1]}})
      y_next = sum[SW-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
  end
`else
  // Upper sum bits are intentionally discarded by the two's-complement wrap.
  logic sum_hi_unused;
  assign sum_hi_unused = ^sum[SW-1:DATA_SIZE];
  always_comb begin
    y_next = sum[DATA_SIZE-1:0];
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = pop ? MAC : IDLE;
      MAC:     next_state = WRITE;
      WRITE:   next_state = push ? IDLE : WRITE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_rd_en  = 1'b0;
    bus.out_wr_en = 1'b0;
    case (state)
      IDLE:    bus.in_rd_en  = pop;
      MAC:     ;
      WRITE:   bus.out_wr_en = push;
      default: begin
        bus.in_rd_en  = 1'bx;
        bus.out_wr_en = 1'bx;
      end
    endcase
  end

  // History only moves on a completed pop (x) or a completed push (y).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x0    <= '0;
      x1    <= '0;
      y1    <= '0;
      y_reg <= '0;
    end else begin
      if (pop) begin
        x1 <= x0;
        x0 <= bus.in;
      end
      if (state == MAC)
        y_reg <= y_next;
      if (push)
        y1 <= y_reg;
    end
  end

  assign bus.out = y_reg;

endmodule

// File: tb/tb_iir_deemph.sv
// Self-checking bench for iir_deemph: a default-coefficient instance and a 1024/1024 saturation
// instance run in lockstep against an integer-arithmetic reference model.
module tb_iir_deemph;

  localparam int     BITS = 10;
  localparam longint C0   = 178;
  localparam longint C1   = 178;
  localparam longint CY   = 667;
  localparam longint S0   = 1024;
  localparam longint S1   = 1024;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -MAXV - 1;

`ifdef IIR_SAT_EN
  localparam int SAT2 = 2147483647;
`else
  localparam int SAT2 = 1398800381;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  longint hx_d, hy_d, hx_s, hy_s;

  iir_deemph_if #(.DATA_SIZE(32)) bus ();
  iir_deemph_if #(.DATA_SIZE(32)) bus_sat ();

  assign bus_sat.in       = bus.in;
  assign bus_sat.in_empty = bus.in_empty;
  assign bus_sat.out_full = bus.out_full;

  iir_deemph dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  iir_deemph #(
    .X_COEFF0 (1024),
    .X_COEFF1 (1024)
  ) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bus_sat)
  );

  always #5 clock = ~clock;

  function automatic longint dq(input longint v);
    return v / (longint'(1) << BITS);
  endfunction

  function automatic int reduce(input longint s);
`ifdef IIR_SAT_EN
    if (s > MAXV) return int'(MAXV);
    if (s < MINV) return int'(MINV);
    return int'(s);
`else
    return int'(s);
`endif
  endfunction

  task automatic model_reset();
    hx_d = 0; hy_d = 0; hx_s = 0; hy_s = 0;
  endtask

  task automatic model_step(input int x, output int e_d, output int e_s);
    e_d  = reduce(dq(longint'(x) * C0) + dq(hx_d * C1) + dq(hy_d * CY));
    e_s  = reduce(dq(longint'(x) * S0) + dq(hx_s * S1) + dq(hy_s * CY));
    hx_d = x;  hy_d = e_d;
    hx_s = x;  hy_s = e_s;
  endtask

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Feeds one sample, holds out_full for 'hold' WRITE cycles, optionally toggles in_empty while waiting.
  task automatic apply_stimulus(input int x, input int hold, input bit toggle,
                                output int obs_d, output int obs_s);
    int  e_d, e_s;
    bit  popped;
    model_step(x, e_d, e_s);
    popped = 1'b0;
    obs_d  = 0;
    obs_s  = 0;
    for (int c = 0; c < 8 && !popped; c++) begin
      @(negedge clock);
      bus.in       = x;
      bus.out_full = 1'b0;
      bus.in_empty = toggle ? (c % 2 == 0) : 1'b0;
      #1;
      if (toggle)
        check_output("rd_while_empty", bus.in_rd_en & bus.in_empty, 0);
      if (bus.in_rd_en === 1'b1)
        popped = 1'b1;
    end
    check_output("pop_seen", popped, 1);
    if (!popped) return;

    @(negedge clock);
    bus.in_empty = 1'b0;
    bus.out_full = 1'($urandom_range(0, 1));
    #1;
    check_output("mac_rd_en", bus.in_rd_en, 0);
    check_output("mac_wr_en", bus.out_wr_en, 0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      bus.out_full = 1'b1;
      #1;
      check_output("hold_wr_en", bus.out_wr_en, 0);
      check_output("hold_rd_en", bus.in_rd_en, 0);
      check_output("hold_out", bus.out, e_d);
    end

    @(negedge clock);
    bus.out_full = 1'b0;
    #1;
    check_output("write_wr_en", bus.out_wr_en, 1);
    check_output("write_wr_en_sat", bus_sat.out_wr_en, 1);
    check_output("write_out", bus.out, e_d);
    check_output("write_out_sat", bus_sat.out, e_s);
    obs_d = bus.out;
    obs_s = bus_sat.out;

    @(negedge clock);
    bus.in_empty = 1'b1;
    bus.out_full = 1'($urandom_range(0, 1));
    #1;
    check_output("single_write", bus.out_wr_en, 0);
  endtask

  initial begin
    int od, os;
    bus.in       = 32'sd5;
    bus.in_empty = 1'b0;
    bus.out_full = 1'b0;
    model_reset();

    $display("[TB] reset state");
    repeat (2) @(negedge clock);
    #1;
    check_output("reset_rd_en", bus.in_rd_en, 0);
    check_output("reset_wr_en", bus.out_wr_en, 0);
    check_output("reset_out", bus.out, 0);
    check_output("reset_out_sat", bus_sat.out, 0);
    bus.in_empty = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] impulse");
    apply_stimulus(1024, 0, 1'b0, od, os);  check_output("impulse0", od, 178);
    apply_stimulus(0,    0, 1'b0, od, os);  check_output("impulse1", od, 293);
    apply_stimulus(0,    0, 1'b0, od, os);  check_output("impulse2", od, 190);

    $display("[TB] negative symmetry");
    do_reset();
    apply_stimulus(-1024, 0, 1'b0, od, os); check_output("neg0", od, -178);
    apply_stimulus(0,     0, 1'b0, od, os); check_output("neg1", od, -293);

    $display("[TB] backpressure");
    do_reset();
    apply_stimulus(1024, 5, 1'b0, od, os);  check_output("bp0", od, 178);
    apply_stimulus(0,    0, 1'b0, od, os);  check_output("bp1", od, 293);

    $display("[TB] empty stall");
    do_reset();
    apply_stimulus(1024, 0, 1'b1, od, os);  check_output("stall0", od, 178);
    apply_stimulus(0,    0, 1'b1, od, os);  check_output("stall1", od, 293);
    apply_stimulus(0,    0, 1'b1, od, os);  check_output("stall2", od, 190);

    $display("[TB] reset mid-operation");
    do_reset();
    @(negedge clock);
    bus.in       = 1024;
    bus.in_empty = 1'b0;
    #1;
    check_output("midop_pop", bus.in_rd_en, 1);
    @(negedge clock);
    reset        = 1'b1;
    bus.in_empty = 1'b0;
    #1;
    check_output("midop_out", bus.out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check_output("midop_wr_en", bus.out_wr_en, 0);
      check_output("midop_rd_en", bus.in_rd_en, 0);
    end
    @(negedge clock);
    reset        = 1'b0;
    bus.in_empty = 1'b1;
    model_reset();
    apply_stimulus(1024, 0, 1'b0, od, os);  check_output("midop_first", od, 178);

    $display("[TB] saturation");
    do_reset();
    apply_stimulus(2147483647, 0, 1'b0, od, os); check_output("sat0", os, 2147483647);
    apply_stimulus(2147483647, 0, 1'b0, od, os); check_output("sat1", os, SAT2);

    $display("[TB] random stream");
    do_reset();
    for (int n = 0; n < 30; n++) begin
      int x;
      x = (n % 3 == 0) ? int'($urandom) : int'($urandom_range(0, 200000)) - 100000;
      apply_stimulus(x, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), od, os);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
